// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/write-back sequencer for the 8-bit datapath.
// Outputs decode from the current state and ir, so reset clears every strobe and request at once.
module cpu_sequencer #(
  parameter int         CNT_W   = 16,
  parameter logic [7:0] HALT_OP = 8'hFF
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             run,
  input  logic             step,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [7:0]       instr,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic             zero,
  output logic [7:0]       ir,
  output logic             pc_en,
  output logic             branch,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  // state  | meaning
  // IDLE   | waiting for run or step
  // FETCH  | imem_req held until imem_ack, ir loads on the ack edge
  // DECODE | one cycle with ir stable
  // EXEC   | ALU/LW/SW dispatch, BEQ retires, HALT detected
  // MEM    | dmem_req held until dmem_ack, SW retires on the ack cycle
  // WB     | register write, ALU/LW retire
  // HALT   | absorbing until reset
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  state_t           r_state;
  logic [7:0]       r_ir;
  logic [CNT_W-1:0] r_count;

  logic [1:0] w_op;
  logic       w_is_halt;
  logic       w_retire;

  assign w_op      = r_ir[7:6];
  assign w_is_halt = (r_ir == HALT_OP);

  // HALT_OP shares the BEQ opcode field, so it is excluded before BEQ is considered.
  assign w_retire = ((r_state == S_EXEC) && !w_is_halt && (w_op == OP_BEQ))
                 || ((r_state == S_MEM) && dmem_ack && (w_op == OP_SW))
                 ||  (r_state == S_WB);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE:   if (run || step) r_state <= S_FETCH;
        S_FETCH:  if (imem_ack) begin
                    r_ir    <= instr;
                    r_state <= S_DECODE;
                  end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC:   if (w_is_halt)                          r_state <= S_HALT;
                  else if (w_op == OP_LW || w_op == OP_SW) r_state <= S_MEM;
                  else if (w_op == OP_ALU)                 r_state <= S_WB;
        S_MEM:    if (dmem_ack && (w_op == OP_LW)) r_state <= S_WB;
        S_WB:     r_state <= S_WB;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_IDLE;
      endcase
      // Retire overrides the per-state next state: chain straight into FETCH or drop to IDLE.
      if (w_retire) begin
        r_count <= r_count + CNT_W'(1);
        r_state <= run ? S_FETCH : S_IDLE;
      end
    end
  end

  assign imem_req    = (r_state == S_FETCH);
  assign dmem_req    = (r_state == S_MEM);
  assign dmem_we     = (r_state == S_MEM) && (w_op == OP_SW);
  assign pc_en       = w_retire;
  assign branch      = (r_state == S_EXEC) && !w_is_halt && (w_op == OP_BEQ) && zero;
  assign reg_write   = (r_state == S_WB);
  assign mem_to_reg  = (r_state == S_WB) && (w_op == OP_LW);
  assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted      = (r_state == S_HALT);
  assign ir          = r_ir;
  assign instr_count = r_count;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: memory responders push expected retirements,
// a monitor pops and compares them whenever the sequencer strobes pc_en.
module tb_cpu_sequencer;
  localparam int CW = 8;

  logic          CLK = 1'b0, RESET_N = 1'b0, run = 1'b0, step = 1'b0;
  logic          imem_ack = 1'b0, dmem_ack = 1'b0, zero = 1'b0;
  logic [7:0]    instr = 8'h00;
  logic          imem_req, dmem_req, dmem_we, pc_en, branch, reg_write, mem_to_reg, busy, halted;
  logic [7:0]    ir;
  logic [CW-1:0] instr_count;

  cpu_sequencer #(.CNT_W(CW), .HALT_OP(8'hFF)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .run(run), .step(step),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .zero(zero),
    .ir(ir), .pc_en(pc_en), .branch(branch), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .busy(busy), .halted(halted), .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [7:0] ins; int idel; int ddel; logic z; } pent_t;
  typedef struct { logic [7:0] ir; logic br; logic rw; logic mtr; logic sw; int ret_cyc; logic [CW-1:0] cnt; } exp_t;

  pent_t         prog[$];
  exp_t          sb[$];
  int            ret_log[$];
  int            cyc = 0, n_cmp = 0, n_bad = 0, start_cyc = 0;
  logic [CW-1:0] model_cnt = '0;
  pent_t         cur;
  bit            in_fetch = 0, cnt_pend = 0, bub_pend = 0;
  int            icnt = 0, dcnt = 0;
  logic [CW-1:0] pend_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Instruction memory: pops a program entry at the start of each fetch and pushes the expected retirement.
  initial forever begin
    @(posedge CLK); #1;
    if (!RESET_N) begin
      imem_ack = 1'b0;
    end else if (imem_req) begin
      if (!in_fetch && prog.size() > 0) begin
        cur = prog.pop_front();
        in_fetch = 1;
        icnt = cur.idel;
      end
      if (in_fetch && icnt == 0) begin
        exp_t e;
        int   lat;
        imem_ack = 1'b1;
        instr    = cur.ins;
        zero     = cur.z;
        dcnt     = cur.ddel;
        in_fetch = 0;
        if (cur.ins != 8'hFF) begin
          e.ir = cur.ins; e.br = 1'b0; e.rw = 1'b0; e.mtr = 1'b0; e.sw = 1'b0;
          case (cur.ins[7:6])
            2'b00:   begin e.rw = 1'b1; lat = 3; end
            2'b01:   begin e.rw = 1'b1; e.mtr = 1'b1; lat = 4 + cur.ddel; end
            2'b10:   begin e.sw = 1'b1; lat = 3 + cur.ddel; end
            default: begin e.br = cur.z; lat = 2; end
          endcase
          model_cnt = model_cnt + CW'(1);
          e.cnt     = model_cnt;
          e.ret_cyc = cyc + lat;
          sb.push_back(e);
        end
      end else begin
        imem_ack = 1'b0;
        instr    = 8'($urandom);
        if (in_fetch) icnt--;
      end
    end else begin
      imem_ack = 1'($urandom);
      instr    = 8'($urandom);
    end
  end

  // Data memory: acknowledges after the delay chosen when the instruction was fetched; junk acks otherwise.
  initial forever begin
    @(posedge CLK); #1;
    if (!RESET_N)      dmem_ack = 1'b0;
    else if (dmem_req) begin
      if (dcnt == 0) dmem_ack = 1'b1;
      else begin dmem_ack = 1'b0; dcnt--; end
    end else           dmem_ack = 1'($urandom);
  end

  initial forever begin
    @(negedge CLK);
    if (RESET_N) begin
      if (cnt_pend) begin check("instr_count_after_retire", 64'(instr_count), 64'(pend_cnt)); cnt_pend = 0; end
      if (bub_pend) begin check("fetch_right_after_retire", 64'(imem_req), 64'd1); bub_pend = 0; end
      if (dmem_req && sb.size() > 0) check("dmem_we", 64'(dmem_we), 64'(sb[0].sw));
      if (imem_req || dmem_req || pc_en) check("busy", 64'(busy), 64'd1);
      if (reg_write) check("reg_write_with_pc_en", 64'(pc_en), 64'd1);
      if (pc_en) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pc_en: got pc_en=1 expected no retire (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ir", 64'(ir), 64'(e.ir));
          check("branch", 64'(branch), 64'(e.br));
          check("reg_write", 64'(reg_write), 64'(e.rw));
          if (e.rw) check("mem_to_reg", 64'(mem_to_reg), 64'(e.mtr));
          check("retire_cycle", 64'(cyc), 64'(e.ret_cyc));
          cnt_pend = 1; pend_cnt = e.cnt; bub_pend = run;
          ret_log.push_back(cyc);
        end
      end
    end
  end

  task automatic reset_checks();
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_dmem_req", 64'(dmem_req), 64'd0);
    check("rst_dmem_we", 64'(dmem_we), 64'd0);
    check("rst_pc_en", 64'(pc_en), 64'd0);
    check("rst_branch", 64'(branch), 64'd0);
    check("rst_reg_write", 64'(reg_write), 64'd0);
    check("rst_mem_to_reg", 64'(mem_to_reg), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_ir", 64'(ir), 64'd0);
    check("rst_instr_count", 64'(instr_count), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK); #2;
    RESET_N = 1'b0; run = 1'b0; step = 1'b0;
    prog.delete(); sb.delete();
    model_cnt = '0; in_fetch = 0; dcnt = 0; cnt_pend = 0; bub_pend = 0;
    #1 reset_checks();
    @(negedge CLK); #2;
    RESET_N = 1'b1;
    @(posedge CLK); #2;
    check("idle_after_release_busy", 64'(busy), 64'd0);
    check("idle_after_release_req", 64'(imem_req), 64'd0);
  endtask

  task automatic run_prog(input bit use_step);
    int k;
    @(posedge CLK); #2;
    start_cyc = cyc;
    if (use_step) step = 1'b1; else run = 1'b1;
    if (use_step) begin @(posedge CLK); #2; step = 1'b0; end
    k = 0;
    while (!(prog.size() == 0 && !in_fetch) && k < 5000) begin @(posedge CLK); #2; k++; end
    check("program_consumed", 64'(k < 5000), 64'd1);
    run = 1'b0;
    k = 0;
    while (busy && k < 100) begin @(posedge CLK); #2; k++; end
    check("back_to_idle", 64'(busy), 64'd0);
    repeat (2) @(posedge CLK);
    #2 check("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  function automatic pent_t rnd_entry();
    pent_t p;
    p.ins = 8'($urandom);
    if (p.ins == 8'hFF) p.ins = 8'hFE;
    p.idel = int'($urandom_range(0, 3));
    p.ddel = int'($urandom_range(0, 3));
    p.z    = 1'($urandom);
    return p;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq, k;
    logic [CW-1:0] base;

    do_reset();

    // ALU, LW, SW back to back with same-cycle acks
    ret_log.delete();
    prog.push_back('{8'h05, 0, 0, 1'b0});
    prog.push_back('{8'h45, 0, 0, 1'b0});
    prog.push_back('{8'h85, 0, 0, 1'b0});
    run_prog(0);
    check("retire_count_3", 64'(ret_log.size()), 64'd3);
    if (ret_log.size() >= 3) begin
      check("pc_en_cycle_alu", 64'(ret_log[0] - start_cyc), 64'd4);
      check("pc_en_cycle_lw",  64'(ret_log[1] - start_cyc), 64'd9);
      check("pc_en_cycle_sw",  64'(ret_log[2] - start_cyc), 64'd13);
    end
    check("instr_count_3", 64'(instr_count), 64'd3);

    // BEQ taken then not taken
    prog.push_back('{8'hC3, 0, 0, 1'b1});
    prog.push_back('{8'hC3, 0, 0, 1'b0});
    run_prog(0);

    // Single step with a 3-cycle fetch delay, and a second step while busy
    base = model_cnt;
    prog.push_back('{8'h07, 3, 0, 1'b0});
    nreq = 0;
    @(posedge CLK); #2 step = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(posedge CLK); #2;
      if (k == 0) step = 1'b0;
      if (k == 2) begin check("busy_at_second_step", 64'(busy), 64'd1); step = 1'b1; end
      if (k == 3) step = 1'b0;
      if (imem_req) nreq++;
    end
    check("step_imem_req_cycles", 64'(nreq), 64'd4);
    check("step_one_retire", 64'(instr_count), 64'(base + CW'(1)));
    check("step_idle_busy", 64'(busy), 64'd0);
    check("step_idle_req", 64'(imem_req), 64'd0);

    // Reset while waiting in MEM
    do_reset();
    prog.push_back('{8'h45, 0, 20, 1'b0});
    @(posedge CLK); #2 run = 1'b1;
    k = 0;
    while (!dmem_req && k < 20) begin @(negedge CLK); k++; end
    check("dmem_req_before_reset", 64'(dmem_req), 64'd1);
    do_reset();

    // Randomised batches in free-run and single-step
    for (int b = 0; b < 40; b++) begin
      if ($urandom_range(0, 2) == 0) begin
        prog.push_back(rnd_entry());
        run_prog(1);
      end else begin
        int n = int'($urandom_range(1, 6));
        for (int i = 0; i < n; i++) prog.push_back(rnd_entry());
        run_prog(0);
      end
    end
    check("random_count", 64'(instr_count), 64'(model_cnt));

    // HALT is absorbing, run and step ignored
    do_reset();
    prog.push_back('{8'h3C, 0, 0, 1'b0});
    prog.push_back('{8'hFF, 1, 0, 1'b0});
    @(posedge CLK); #2 run = 1'b1;
    k = 0;
    while (!(prog.size() == 0 && !in_fetch) && k < 100) begin @(posedge CLK); #2; k++; end
    repeat (3) @(posedge CLK);
    #2;
    check("halted", 64'(halted), 64'd1);
    check("halt_busy", 64'(busy), 64'd0);
    check("halt_count", 64'(instr_count), 64'(model_cnt));
    for (int i = 0; i < 10; i++) begin
      run = 1'b1; step = 1'(i % 2);
      @(posedge CLK); #2;
      check("halt_stays", 64'(halted), 64'd1);
      check("halt_no_fetch", 64'(imem_req), 64'd0);
    end
    check("halt_count_after", 64'(instr_count), 64'(model_cnt));
    do_reset();
    check("halt_cleared", 64'(halted), 64'd0);

    // Counter wrap
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      pent_t p = rnd_entry();
      p.idel = int'($urandom_range(0, 1));
      p.ddel = int'($urandom_range(0, 1));
      prog.push_back(p);
    end
    run_prog(0);
    check("count_max", 64'(instr_count), 64'((1 << CW) - 1));
    prog.push_back('{8'h12, 0, 0, 1'b0});
    run_prog(0);
    check("count_wrap", 64'(instr_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
